mult_div_unit: RTL and testbench

//   Multi-cycle signed multiplier/divider that owns the HI and LO registers.
//   Its hi_output/lo_output feed the write-back select mux (selects 2 and 3).
//   It serves MULT and DIV. The control FSM stalls on busy and advances on done.

---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle signed multiplier/divider that owns the HI and LO registers.
//   A multiply or divide takes WIDTH iterations, one per clock. The result
//   is written to HI/LO only on the final iteration. Between operations
//   HI/LO hold their value.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; aborts any operation in flight
//   start_mult  request signed multiply a*b (wins over start_div)
//   start_div   request signed divide a/b
//   a, b        operands (multiplicand/dividend, multiplier/divisor)
//   hi_output   HI register (product upper half / remainder)
//   lo_output   LO register (product lower half / quotient)
//   busy        operation in progress
//   done        one-cycle pulse when HI/LO have just been updated
//   div_zero    one-cycle pulse when a divide by zero was rejected
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_output,
  output logic [WIDTH-1:0] lo_output,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t         state;
  logic [CW-1:0]  count;

  // Booth multiplier: the accumulator carries one extra sign bit so that
  // subtracting the most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   mul_acc;
  logic [WIDTH-1:0] mul_q;
  logic             mul_qm1;
  logic [WIDTH:0]   mcand;

  // Restoring divider on magnitudes; signs are applied at the end.
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_dvs;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mul_acc_next;
  logic [WIDTH-1:0] mul_q_next;
  logic             mul_qm1_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;
  logic             last_iter;

  // One Booth step: add or subtract the multiplicand depending on the
  // current multiplier bit pair, then arithmetic-shift {acc, q, q-1} right.
  // One restoring-divide step: shift in the next dividend bit and subtract
  // the divisor if it fits. The final values with signs applied are also
  // formed here so HI/LO can be loaded on the last iteration's edge.
  always_comb begin
    booth_sum = mul_acc;
    case ({mul_q[0], mul_qm1})
      2'b01:   booth_sum = mul_acc + mcand;
      2'b10:   booth_sum = mul_acc - mcand;
      default: booth_sum = mul_acc;
    endcase
    mul_acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_q_next   = {booth_sum[0], mul_q[WIDTH-1:1]};
    mul_qm1_next = mul_q[0];

    div_shift    = {div_rem, div_quo[WIDTH-1]};
    div_diff     = div_shift - {1'b0, div_dvs};
    div_rem_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_quo_next = {div_quo[WIDTH-2:0], ~div_diff[WIDTH]};

    quo_final = neg_q ? -div_quo_next : div_quo_next;
    rem_final = neg_r ? -div_rem_next : div_rem_next;

    last_iter = (count == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers. done and div_zero default low every
  // cycle so they can only ever be single-cycle pulses. Starts are only
  // looked at in IDLE, so requests made while busy are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      mul_acc   <= '0;
      mul_q     <= '0;
      mul_qm1   <= 1'b0;
      mcand     <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvs   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi_output <= '0;
      lo_output <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (start_mult) begin
            mul_acc <= '0;
            mul_q   <= b;
            mul_qm1 <= 1'b0;
            mcand   <= {a[WIDTH-1], a};
            busy    <= 1'b1;
            state   <= MULT;
          end else if (start_div && (b != '0)) begin
            div_rem <= '0;
            div_quo <= a[WIDTH-1] ? -a : a;
            div_dvs <= b[WIDTH-1] ? -b : b;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r   <= a[WIDTH-1];
            busy    <= 1'b1;
            state   <= DIV;
          end else if (start_div) begin
            div_zero <= 1'b1;
          end
        end
        MULT: begin
          mul_acc <= mul_acc_next;
          mul_q   <= mul_q_next;
          mul_qm1 <= mul_qm1_next;
          count   <= count + 1'b1;
          if (last_iter) begin
            hi_output <= mul_acc_next[WIDTH-1:0];
            lo_output <= mul_q_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        DIV: begin
          div_rem <= div_rem_next;
          div_quo <= div_quo_next;
          count   <= count + 1'b1;
          if (last_iter) begin
            hi_output <= rem_final;
            lo_output <= quo_final;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Scoreboard bench for mult_div_unit. Each request pushes its expected
//   HI/LO (or a divide-by-zero event) into a queue; a monitor on the
//   falling edge pops and compares whenever done or div_zero is seen.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi_output;
  logic [W-1:0] lo_output;
  logic         busy;
  logic         done;
  logic         div_zero;

  typedef struct packed {
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi_output  (hi_output),
    .lo_output  (lo_output),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit signed arithmetic. kind 0=mult, 1=div,
  // 2=both starts (multiply wins).
  function automatic exp_t refModel(input int kind, input logic [W-1:0] ra,
                                    input logic [W-1:0] rb,
                                    input logic [W-1:0] cur_hi,
                                    input logic [W-1:0] cur_lo);
    exp_t e;
    longint sa;
    longint sbv;
    longint p;
    longint q;
    longint r;
    sa  = longint'($signed(ra));
    sbv = longint'($signed(rb));
    e.dz = 1'b0;
    if (kind != 1) begin
      p = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (rb == '0) begin
      e.dz = 1'b1;
      e.hi = cur_hi;
      e.lo = cur_lo;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Issue one request from a falling edge, push its expectation, and follow
  // it to completion. inject>0 pulses start_div at that busy cycle.
  task automatic applyStimulus(input int kind, input logic [W-1:0] sa,
                               input logic [W-1:0] sbv, input int inject);
    exp_t e;
    int   cnt;
    e = refModel(kind, sa, sbv, model_hi, model_lo);
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    a = sa;
    b = sbv;
    start_mult = (kind != 1);
    start_div  = (kind != 0);
    @(posedge clk);
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    if (e.dz) begin
      checkOutput("dz_busy", {31'b0, busy}, 32'd0);
      checkOutput("dz_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      checkOutput("dz_pulse_end", {31'b0, div_zero}, 32'd0);
    end else begin
      cnt = 0;
      while (busy && cnt < 100) begin
        cnt++;
        if (cnt == inject) begin
          a = $urandom;
          b = $urandom | 32'd1;
          start_div = 1'b1;
        end
        @(negedge clk);
        start_div = 1'b0;
      end
      checkOutput("busy_cycles", cnt, W);
      checkOutput("done_at_end", {31'b0, done}, 32'd1);
    end
  endtask

  // Monitor: every done or div_zero pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (done || div_zero)) begin
      checkOutput("done_and_dz", {31'b0, done & div_zero}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: done=%b div_zero=%b with empty queue",
                 done, div_zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("event_kind", {31'b0, div_zero}, {31'b0, e.dz});
        checkOutput("hi", hi_output, e.hi);
        checkOutput("lo", lo_output, e.lo);
      end
    end
  end

  initial begin
    int kind;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    model_hi   = '0;
    model_lo   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_hi", hi_output, 32'd0);
    checkOutput("reset_lo", lo_output, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_dz", {31'b0, div_zero}, 32'd0);

    $display("[TB] directed multiply/divide cases");
    applyStimulus(0, 32'd7, 32'hFFFFFFFD, 0);
    checkOutput("mult_7x-3_hi", hi_output, 32'hFFFFFFFF);
    checkOutput("mult_7x-3_lo", lo_output, 32'hFFFFFFEB);
    applyStimulus(0, 32'h80000000, 32'h80000000, 0);
    checkOutput("mult_minsq_hi", hi_output, 32'h40000000);
    applyStimulus(1, 32'hFFFFFFF9, 32'd2, 0);
    checkOutput("div_-7/2_lo", lo_output, 32'hFFFFFFFD);
    checkOutput("div_-7/2_hi", hi_output, 32'hFFFFFFFF);
    applyStimulus(1, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("div_ovf_lo", lo_output, 32'h80000000);

    $display("[TB] divide by zero keeps HI/LO");
    applyStimulus(0, 32'h00001234, 32'h00056789, 0);
    applyStimulus(1, 32'd5, 32'd0, 0);
    checkOutput("dz_hold_lo", lo_output, 32'h1234 * 32'h56789);

    $display("[TB] ignored start while busy, simultaneous starts");
    applyStimulus(0, 32'd3, 32'd4, 10);
    repeat (5) @(negedge clk);
    checkOutput("ignored_busy", {31'b0, busy}, 32'd0);
    checkOutput("ignored_lo", lo_output, 32'd12);
    applyStimulus(2, 32'd6, 32'hFFFFFFF7, 0);
    checkOutput("both_lo", lo_output, 32'hFFFFFFCA);

    $display("[TB] reset aborts divide");
    a = 32'd100;
    b = 32'd7;
    start_div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_div = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_hi", hi_output, 32'd0);
    checkOutput("abort_lo", lo_output, 32'd0);
    applyStimulus(1, 32'd100, 32'd7, 0);
    checkOutput("div_100/7_lo", lo_output, 32'd14);
    checkOutput("div_100/7_hi", hi_output, 32'd2);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 20);
        3: ra = 32'h80000000;
        default: ;
      endcase
      applyStimulus(kind, ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
